// File: rtl/pc_seq_if.sv
// pc_seq_if: memory fetch port, decode handoff and redirect inputs of pc_sequencer.
interface pc_seq_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        br_valid;
  logic        br_taken;
  logic [15:0] br_imm;
  logic        jmp_valid;
  logic [25:0] jmp_index;
  logic [31:0] br_pc;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_ack, imem_rdata, instr_ready,
           br_valid, br_taken, br_imm, jmp_valid, jmp_index, br_pc
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_ack, imem_rdata, instr_ready,
           br_valid, br_taken, br_imm, jmp_valid, jmp_index, br_pc
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the PC, issues one fetch at a time and applies branch/jump redirects.
// Optional fetch/flush performance counters are enabled by defining PC_SEQ_PERF_EN.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  pc_seq_if.master    bus
`ifdef PC_SEQ_PERF_EN
  ,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] flush_cnt_o
`endif
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {ST_RST, ST_FETCH, ST_DROP, ST_HOLD} state_e;

  state_e            state_q;
  logic [XLEN-1:0]   pc_q;
  logic [XLEN-1:0]   drop_tgt_q;
  logic              req_q;
  logic              valid_q;
  logic [XLEN-1:0]   instr_q;
  logic [XLEN-1:0]   instr_pc_q;

  logic              redirect;
  logic [XLEN-1:0]   seq_pc;
  logic [XLEN-1:0]   br_tgt;
  logic [XLEN-1:0]   jmp_tgt;
  logic [XLEN-1:0]   tgt;

  // Redirect target: jump wins over a taken branch when both resolve together.
  assign seq_pc   = bus.br_pc + XLEN'(4);
  assign br_tgt   = seq_pc + {{14{bus.br_imm[15]}}, bus.br_imm, 2'b00};
  assign jmp_tgt  = {seq_pc[31:28], bus.jmp_index, 2'b00};
  assign redirect = bus.jmp_valid | (bus.br_valid & bus.br_taken);
  assign tgt      = bus.jmp_valid ? jmp_tgt : br_tgt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RST;
      pc_q       <= RESET_PC;
      drop_tgt_q <= '0;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      instr_q    <= '0;
      instr_pc_q <= '0;
    end else begin
      case (state_q)
        ST_RST: begin
          state_q <= ST_FETCH;
          req_q   <= 1'b1;
        end
        ST_FETCH: begin
          if (bus.imem_ack) begin
            if (redirect) begin
              pc_q <= tgt;
            end else begin
              instr_q    <= bus.imem_rdata;
              instr_pc_q <= pc_q;
              pc_q       <= pc_q + XLEN'(4);
              req_q      <= 1'b0;
              valid_q    <= 1'b1;
              state_q    <= ST_HOLD;
            end
          end else if (redirect) begin
            drop_tgt_q <= tgt;
            state_q    <= ST_DROP;
          end
        end
        ST_DROP: begin
          // Address stays on the abandoned fetch until memory answers it.
          if (bus.imem_ack) begin
            pc_q    <= redirect ? tgt : drop_tgt_q;
            state_q <= ST_FETCH;
          end else if (redirect) begin
            drop_tgt_q <= tgt;
          end
        end
        ST_HOLD: begin
          if (redirect) begin
            pc_q    <= tgt;
            valid_q <= 1'b0;
            req_q   <= 1'b1;
            state_q <= ST_FETCH;
          end else if (bus.instr_ready) begin
            valid_q <= 1'b0;
            req_q   <= 1'b1;
            state_q <= ST_FETCH;
          end
        end
        default: begin
          state_q <= ST_RST;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = valid_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;

`ifdef PC_SEQ_PERF_EN
  logic            fetch_inc;
  logic            flush_inc;
  logic [XLEN-1:0] fetch_cnt_q;
  logic [XLEN-1:0] flush_cnt_q;

  assign fetch_inc = (state_q == ST_FETCH) & bus.imem_ack & ~redirect;
  assign flush_inc = (state_q != ST_RST) & redirect;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (fetch_inc) fetch_cnt_q <= fetch_cnt_q + XLEN'(1);
      if (flush_inc) flush_cnt_q <= flush_cnt_q + XLEN'(1);
    end
  end

  assign fetch_cnt_o = fetch_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and random stimulus for pc_sequencer checked against a
// transaction-level model of the fetch/handoff/redirect rules.
module tb_pc_sequencer;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pc_seq_if bus();

`ifdef PC_SEQ_PERF_EN
  logic [31:0] fetch_cnt;
  logic [31:0] flush_cnt;
`endif

  pc_sequencer #(.RESET_PC(RST_PC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef PC_SEQ_PERF_EN
    ,
    .fetch_cnt_o (fetch_cnt),
    .flush_cnt_o (flush_cnt)
`endif
  );

  int checks = 0;
  int failures = 0;

  // Model: boot pending, one outstanding fetch (possibly doomed), one buffered instruction.
  bit          m_boot;
  bit          m_pending;
  bit          m_discard;
  logic [31:0] m_addr;
  logic [31:0] m_tgt;
  bit          m_bufv;
  logic [31:0] m_binstr;
  logic [31:0] m_bpc;
`ifdef PC_SEQ_PERF_EN
  logic [31:0] m_fetch;
  logic [31:0] m_flush;
`endif

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] branch_target(input logic [31:0] pc, input logic [15:0] imm);
    int off;
    off = int'($signed(imm));
    return pc + 32'd4 + 32'(off * 4);
  endfunction

  function automatic logic [31:0] jump_target(input logic [31:0] pc, input logic [25:0] idx);
    return ((pc + 32'd4) & 32'hF000_0000) | (32'(idx) << 2);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_boot = 1; m_pending = 0; m_discard = 0; m_addr = RST_PC; m_tgt = '0;
    m_bufv = 0; m_binstr = '0; m_bpc = '0;
`ifdef PC_SEQ_PERF_EN
    m_fetch = '0; m_flush = '0;
`endif
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req"},   32'(bus.imem_req), 32'd0);
    chk({tag, "_addr"},  bus.imem_addr, RST_PC);
    chk({tag, "_valid"}, 32'(bus.instr_valid), 32'd0);
    chk({tag, "_instr"}, bus.instr, 32'd0);
    chk({tag, "_ipc"},   bus.instr_pc, 32'd0);
`ifdef PC_SEQ_PERF_EN
    chk({tag, "_fetch_cnt"}, fetch_cnt, 32'd0);
    chk({tag, "_flush_cnt"}, flush_cnt, 32'd0);
`endif
  endtask

  task automatic set_idle();
    bus.imem_ack = 0; bus.instr_ready = 0; bus.br_valid = 0; bus.br_taken = 0;
    bus.br_imm = '0; bus.jmp_valid = 0; bus.jmp_index = '0; bus.br_pc = '0;
  endtask

  // Advance one clock: update the model from this cycle's inputs, then compare after the edge.
  task automatic tick();
    bit r;
    logic [31:0] t;
    bus.imem_rdata = mem_word(bus.imem_addr);
    r = bus.jmp_valid | (bus.br_valid & bus.br_taken);
    t = bus.jmp_valid ? jump_target(bus.br_pc, bus.jmp_index)
                      : branch_target(bus.br_pc, bus.br_imm);
    if (m_boot) begin
      m_boot = 0;
      m_pending = 1;
    end else begin
`ifdef PC_SEQ_PERF_EN
      if (r) m_flush++;
`endif
      if (m_pending) begin
        if (bus.imem_ack) begin
          if (!m_discard && !r) begin
            m_bufv = 1; m_binstr = mem_word(m_addr); m_bpc = m_addr;
            m_addr = m_addr + 32'd4; m_pending = 0;
`ifdef PC_SEQ_PERF_EN
            m_fetch++;
`endif
          end else begin
            m_addr = r ? t : m_tgt;
            m_discard = 0;
          end
        end else if (r) begin
          m_discard = 1;
          m_tgt = t;
        end
      end else if (r || bus.instr_ready) begin
        m_bufv = 0;
        m_pending = 1;
        if (r) m_addr = t;
      end
    end
    @(posedge clk);
    #1;
    chk("imem_req",    32'(bus.imem_req), 32'(m_pending));
    chk("imem_addr",   bus.imem_addr, m_addr);
    chk("instr_valid", 32'(bus.instr_valid), 32'(m_bufv));
    if (m_bufv) begin
      chk("instr",    bus.instr, m_binstr);
      chk("instr_pc", bus.instr_pc, m_bpc);
    end
`ifdef PC_SEQ_PERF_EN
    chk("fetch_cnt", fetch_cnt, m_fetch);
    chk("flush_cnt", flush_cnt, m_flush);
`endif
  endtask

  initial begin
    logic [31:0] held_pc;
    set_idle();
    bus.imem_rdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");
    @(negedge clk);
    rst_n = 1;

    // Zero-wait memory with decode always ready.
    bus.imem_ack = 1; bus.instr_ready = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i % 2 == 0) chk("seq_addr", bus.imem_addr, RST_PC + 32'(4 * (i / 2)));
      else            chk("seq_ipc",  bus.instr_pc,  RST_PC + 32'(4 * (i / 2)));
    end

    // Decode stalls in HOLD; a not-taken branch must not disturb anything.
    held_pc = bus.instr_pc;
    bus.instr_ready = 0;
    for (int i = 0; i < 5; i++) begin
      bus.br_valid = (i >= 2); bus.br_taken = 0; bus.br_imm = 16'h0040;
      bus.br_pc = 32'h0040_0100;
      tick();
      chk("stall_ipc", bus.instr_pc, held_pc);
      chk("stall_req", 32'(bus.imem_req), 32'd0);
    end

    // Taken branch in HOLD kills the buffered instruction.
    bus.imem_ack = 0; bus.br_valid = 1; bus.br_taken = 1;
    bus.br_pc = 32'h0040_0010; bus.br_imm = 16'hFFFC;
    tick();
    chk("br_addr",  bus.imem_addr, 32'h0040_0004);
    chk("br_valid", 32'(bus.instr_valid), 32'd0);

    // Jump coinciding with an ack: data discarded, target fetched next.
    set_idle();
    bus.imem_ack = 1; bus.jmp_valid = 1; bus.br_pc = 32'hF000_0000; bus.jmp_index = 26'h000_0010;
    tick();
    chk("jmp_addr", bus.imem_addr, 32'hF000_0040);

    // Redirect while the fetch is pending; a second redirect replaces the target.
    set_idle();
    bus.br_valid = 1; bus.br_taken = 1; bus.br_pc = 32'h0000_1000; bus.br_imm = 16'h0008;
    tick();
    chk("drop_hold_addr", bus.imem_addr, 32'hF000_0040);
    set_idle();
    tick();
    bus.br_valid = 1; bus.br_taken = 1; bus.br_pc = 32'h0000_2000; bus.br_imm = 16'h0001;
    tick();
    chk("drop_hold_addr2", bus.imem_addr, 32'hF000_0040);
    set_idle();
    bus.imem_ack = 1;
    tick();
    chk("drop_new_tgt", bus.imem_addr, 32'h0000_2008);

    // Reset pulsed while a doomed fetch is outstanding; late ack must be ignored.
    set_idle();
    bus.jmp_valid = 1; bus.br_pc = 32'h1234_5670; bus.jmp_index = 26'h3FF_FFFF;
    tick();
    set_idle();
    #2;
    rst_n = 0;
    #1;
    chk_reset("midreset");
    model_reset();
    bus.imem_ack = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    bus.instr_ready = 1;
    tick();
    chk("boot_addr", bus.imem_addr, RST_PC);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      bus.imem_ack    = ($urandom_range(0, 1) == 1);
      bus.instr_ready = ($urandom_range(0, 9) < 7);
      bus.br_valid    = ($urandom_range(0, 9) == 0);
      bus.br_taken    = ($urandom_range(0, 1) == 1);
      bus.br_imm      = 16'($urandom);
      bus.jmp_valid   = ($urandom_range(0, 19) == 0);
      bus.jmp_index   = 26'($urandom);
      bus.br_pc       = $urandom & 32'hFFFF_FFFC;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
